// File: rtl/rect_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rect_fetch_if                                                |
// | Description : Request, rectangle-ROM and descriptor signals of rect_fetch. |
// |               Optional out_empty appears when RECT_FETCH_EMPTY_FLAG_EN is  |
// |               defined.                                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface rect_fetch_if #(
  parameter int W_DATA = 5,
  parameter int W_ADDR = 14,
  parameter int W_IDX  = 12,
  parameter int W_OFF  = 10
) ();

  logic              req_valid;
  logic [W_IDX-1:0]  req_idx;
  logic              req_ready;

  logic              rom_en;
  logic [W_ADDR-1:0] rom_addr;
  logic [W_DATA-1:0] rom_data;

  logic              out_valid;
  logic              out_ready;
  logic [W_IDX-1:0]  out_idx;
  logic [W_OFF-1:0]  out_a;
  logic [W_OFF-1:0]  out_b;
  logic [W_OFF-1:0]  out_c;
  logic [W_OFF-1:0]  out_d;
`ifdef RECT_FETCH_EMPTY_FLAG_EN
  logic              out_empty;
`endif

  // Requester, ROM and consumer side
  modport master (
    output req_valid, req_idx, rom_data, out_ready,
    input  req_ready, rom_en, rom_addr, out_valid, out_idx,
`ifdef RECT_FETCH_EMPTY_FLAG_EN
    input  out_empty,
`endif
    input  out_a, out_b, out_c, out_d
  );

  // rect_fetch side
  modport slave (
    input  req_valid, req_idx, rom_data, out_ready,
    output req_ready, rom_en, rom_addr, out_valid, out_idx,
`ifdef RECT_FETCH_EMPTY_FLAG_EN
    output out_empty,
`endif
    output out_a, out_b, out_c, out_d
  );

endinterface
`default_nettype wire

// File: rtl/rect_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rect_fetch                                                   |
// | Description : Accepts a feature index, reads its four rectangle words      |
// |               (x, y, w, h) from the rectangle ROM and emits the four       |
// |               integral-image corner offsets A/B/C/D.                       |
// |               Optional feature macro: RECT_FETCH_EMPTY_FLAG_EN adds        |
// |               out_empty = (w == 0 || h == 0).                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rect_fetch #(
  parameter int W_DATA = 5,
  parameter int W_ADDR = 14,
  parameter int W_IDX  = 12,
  parameter int II_W   = 25,
  parameter int W_OFF  = 10
) (
  input  wire logic   clk,
  input  wire logic   rst,
  rect_fetch_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_CALC  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam logic [W_OFF-1:0] C_PITCH = W_OFF'(II_W);

  state_t            r_state;
  logic              r_req_ready;
  logic [W_IDX-1:0]  r_idx;
  logic [W_ADDR-1:0] r_base;
  logic [1:0]        r_k;
  logic              r_fetch_done;
  logic              r_rom_en;
  logic [W_ADDR-1:0] r_rom_addr;

  logic              r_rd_vld;
  logic [1:0]        r_rd_k;
  logic [W_DATA-1:0] r_x;
  logic [W_DATA-1:0] r_y;
  logic [W_DATA-1:0] r_w;

  logic              r_out_valid;
  logic [W_IDX-1:0]  r_out_idx;
  logic [W_OFF-1:0]  r_out_a;
  logic [W_OFF-1:0]  r_out_b;
  logic [W_OFF-1:0]  r_out_c;
  logic [W_OFF-1:0]  r_out_d;

  logic              w_accept;
  logic [W_OFF-1:0]  w_x;
  logic [W_OFF-1:0]  w_y;
  logic [W_OFF-1:0]  w_w;
  logic [W_OFF-1:0]  w_h;
  logic [W_OFF-1:0]  w_a;
  logic [W_OFF-1:0]  w_b;
  logic [W_OFF-1:0]  w_c;
  logic [W_OFF-1:0]  w_d;

  // req_ready is only ever high in IDLE, so this also implies IDLE
  assign w_accept = r_req_ready && bus.req_valid;

  // Fields are zero-extended (or truncated) to the offset width; all sums wrap.
  // h is not stored: it is on rom_data during CALC and used directly.
  assign w_x = W_OFF'(r_x);
  assign w_y = W_OFF'(r_y);
  assign w_w = W_OFF'(r_w);
  assign w_h = W_OFF'(bus.rom_data);
  assign w_a = w_y * C_PITCH + w_x;
  assign w_b = w_a + w_w;
  assign w_c = w_a + w_h * C_PITCH;
  assign w_d = w_c + w_w;

  // ROM read-return tracking: data is valid the cycle after rom_en was seen,
  // and the k-th return lands in x, y, w in order (h is consumed in CALC)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_vld <= 1'b0;
      r_rd_k   <= 2'd0;
      r_x      <= '0;
      r_y      <= '0;
      r_w      <= '0;
    end else begin
      r_rd_vld <= r_rom_en;
      if (w_accept) begin
        r_rd_k <= 2'd0;
      end else if (r_rd_vld) begin
        case (r_rd_k)
          2'd0:    r_x <= bus.rom_data;
          2'd1:    r_y <= bus.rom_data;
          2'd2:    r_w <= bus.rom_data;
          default: ;
        endcase
        r_rd_k <= r_rd_k + 2'd1;
      end
    end
  end

`ifdef RECT_FETCH_EMPTY_FLAG_EN
  logic r_out_empty;
  logic w_empty;

  assign w_empty       = (r_w == '0) || (bus.rom_data == '0);
  assign bus.out_empty = r_out_empty;

  // Empty flag is registered on the same edge as the corners
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_empty <= 1'b0;
    end else if (r_state == S_CALC) begin
      r_out_empty <= w_empty;
    end
  end
`endif

  // Control FSM with registered handshake, ROM and descriptor outputs.
  // FETCH issues four reads, then waits one cycle so the last read returns
  // while in CALC; this puts out_valid six edges after the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b0;
      r_idx        <= '0;
      r_base       <= '0;
      r_k          <= 2'd0;
      r_fetch_done <= 1'b0;
      r_rom_en     <= 1'b0;
      r_rom_addr   <= '0;
      r_out_valid  <= 1'b0;
      r_out_idx    <= '0;
      r_out_a      <= '0;
      r_out_b      <= '0;
      r_out_c      <= '0;
      r_out_d      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_ready  <= 1'b0;
            r_idx        <= bus.req_idx;
            r_base       <= W_ADDR'({bus.req_idx, 2'b00});
            r_k          <= 2'd0;
            r_fetch_done <= 1'b0;
            r_state      <= S_FETCH;
          end else begin
            r_req_ready  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (!r_fetch_done) begin
            r_rom_en   <= 1'b1;
            r_rom_addr <= r_base + W_ADDR'(r_k);
            r_k        <= r_k + 2'd1;
            if (r_k == 2'd3) begin
              r_fetch_done <= 1'b1;
            end
          end else begin
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          r_out_a     <= w_a;
          r_out_b     <= w_b;
          r_out_c     <= w_c;
          r_out_d     <= w_d;
          r_out_idx   <= r_idx;
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rom_en    = r_rom_en;
  assign bus.rom_addr  = r_rom_addr;
  assign bus.out_valid = r_out_valid;
  assign bus.out_idx   = r_out_idx;
  assign bus.out_a     = r_out_a;
  assign bus.out_b     = r_out_b;
  assign bus.out_c     = r_out_c;
  assign bus.out_d     = r_out_d;

endmodule
`default_nettype wire

// File: doc/rect_fetch.md
RECT_FETCH -- requirements
Module: rect_fetch

Interface
REQ-001 SHALL have parameter W_DATA, default 5: width of one rectangle field word returned by the rectangle ROM.
REQ-002 SHALL have parameter W_ADDR, default 14: rectangle ROM address width.
REQ-003 SHALL have parameter W_IDX, default 12: feature index width.
REQ-004 SHALL have parameter II_W, default 25: integral-image row pitch in words.
REQ-005 SHALL have parameter W_OFF, default 10: corner offset width.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port req_valid, input, 1: a feature index is offered.
REQ-009 SHALL have port req_idx, input, W_IDX: the feature index.
REQ-010 SHALL have port req_ready, output, 1: the block accepts a request.
REQ-011 SHALL have port rom_en, output, 1: rectangle ROM read enable.
REQ-012 SHALL have port rom_addr, output, W_ADDR: rectangle ROM address.
REQ-013 SHALL have port rom_data, input, W_DATA: ROM read data, registered, valid 1 cycle after rom_en.
REQ-014 SHALL have port out_valid, output, 1: a rectangle descriptor is available.
REQ-015 SHALL have port out_ready, input, 1: the consumer accepts the descriptor.
REQ-016 SHALL have port out_idx, output, W_IDX: echo of the accepted req_idx.
REQ-017 SHALL have ports out_a, out_b, out_c, out_d, output, W_OFF each: corner offsets top-left, top-right, bottom-left, bottom-right.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, CALC, OUT.
REQ-019 SHALL assert req_ready only in IDLE; a request is accepted on an edge with req_valid && req_ready.
REQ-020 On accept, SHALL capture req_idx, set base = {req_idx,2'b00} truncated to W_ADDR (modulo wrap), clear 2-bit counter k, and go IDLE->FETCH.
REQ-021 In FETCH, SHALL drive rom_en=1 and rom_addr=base+k (mod 2^W_ADDR) for k=0..3 on 4 consecutive cycles; rom_en=0 in all other states.
REQ-022 SHALL capture rom_data one cycle after each read, into x, y, w, h in order k=0,1,2,3.
REQ-023 SHALL go FETCH->CALC after the k=3 read issues; CALC SHALL last one cycle, during which h is captured and the corners are computed.
REQ-024 Corner arithmetic, with fields zero-extended and all results truncated to W_OFF bits:
- A = y*II_W + x
- B = A + w
- C = A + h*II_W
- D = C + w
REQ-025 SHALL register the corners into out_a..out_d at the CALC->OUT edge; out_valid SHALL rise exactly 6 edges after the accepting edge.
REQ-026 In OUT, SHALL hold out_valid and all out_* stable until out_ready=1; then go OUT->IDLE with out_valid=0 the next cycle.
REQ-027 Minimum request spacing is 7 cycles; req_valid arriving outside IDLE SHALL be held off (req_ready=0) with no loss or overwrite.
REQ-028 out_valid && out_ready on the same edge as a new req_valid SHALL NOT accept the request; it is accepted one cycle later in IDLE.

Reset
REQ-029 rst=1 at any edge, including mid-FETCH or in OUT, SHALL force IDLE and zero all outputs: req_ready=0 during reset, 1 the first cycle after; rom_en=0, rom_addr=0, out_valid=0, out_idx and out_a..out_d=0.
REQ-030 Reset SHALL discard any in-flight fetch, and no descriptor from it SHALL be emitted.

Configuration
REQ-031 Macro RECT_FETCH_EMPTY_FLAG_EN, when defined, SHALL add output out_empty (1 bit, reset 0), registered with the corners, equal to (w==0 || h==0).
REQ-032 When RECT_FETCH_EMPTY_FLAG_EN is undefined, out_empty SHALL be absent and all other behaviour identical.

Verification
REQ-033 Idx 35, ROM words 140..143 = 0x0C,0x0C,0x07,0x06 -> rom_addr 140..143 on 4 consecutive cycles; A=312, B=319, C=462, D=469; out_valid rises on the 6th edge after accept.
REQ-034 Idx 48, words 192..195 = 0x05,0x0C,0x07,0x07 -> A=305, B=312, C=480, D=487.
REQ-035 Idx 0, all words zero -> corners all 0; with RECT_FETCH_EMPTY_FLAG_EN defined, out_empty=1.
REQ-036 out_ready held low 10 cycles with req_valid held high -> outputs stable, req_ready=0 throughout; the second request is accepted 1 cycle after out_ready.
REQ-037 rst pulsed during the k=2 read -> the next cycle is IDLE, rom_en=0 and out_valid=0, and no descriptor appears.
REQ-038 Idx 4095 with W_ADDR=14 -> rom_addr 16380..16383 with no wrap; idx wrap tested with W_ADDR=12 -> addr 4092..4095.
